// File: rtl/cnn_pkg.sv
// Shared CNN pipeline types and constants: fc_ctrl FSM encoding and fc_layer geometry.
package cnn_pkg;

  localparam int unsigned FC_N_IN    = 48;
  localparam int unsigned FC_N_CLASS = 10;
  localparam int unsigned FC_DATA_W  = 8;
  // Holds 0..FC_N_IN inclusive; the read index parks at FC_N_IN for the drain cycle.
  localparam int unsigned FC_CNT_W   = 6;
  localparam int unsigned FC_CLASS_W = 4;
  localparam int unsigned FC_FRAME_W = 16;

  typedef enum logic [1:0] {
    FC_FILL   = 2'd0,
    FC_STREAM = 2'd1,
    FC_WAIT   = 2'd2,
    FC_HOLD   = 2'd3
  } fc_ctrl_state_t;

endpackage

// File: rtl/fc_feat_buf.sv
// Single-frame feature buffer for fc_ctrl: one write port, one read port and their index counters.
module fc_feat_buf
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = FC_DATA_W,
  parameter int unsigned N_IN   = FC_N_IN,
  parameter int unsigned CNT_W  = FC_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data_c,
  output logic              wr_last_c,
  output logic              rd_done_c,
  output logic              wr_first_c
);

  logic [DATA_W-1:0] mem_q [N_IN];
  logic [CNT_W-1:0]  wr_idx_q, wr_idx_d;
  logic [CNT_W-1:0]  rd_idx_q, rd_idx_d;

  assign wr_first_c = (wr_idx_q == '0);
  assign wr_last_c  = (wr_idx_q == CNT_W'(N_IN - 1));
  assign rd_done_c  = (rd_idx_q == CNT_W'(N_IN));
  assign rd_data_c  = rd_done_c ? '0 : mem_q[rd_idx_q];

  // The last write of a frame rewinds both indices so the replay starts at entry 0.
  always_comb begin
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    if (rd_en) begin
      rd_idx_d = rd_idx_q + CNT_W'(1);
    end
    if (wr_en) begin
      if (wr_last_c) begin
        wr_idx_d = '0;
        rd_idx_d = '0;
      end else begin
        wr_idx_d = wr_idx_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
    end else begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  // Contents are meaningless after reset, so the storage itself is not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx_q] <= wr_data;
    end
  end

endmodule

// File: rtl/fc_ctrl.sv
// Frame sequencer in front of fc_layer: fill, replay 48 beats, capture class, hand off result.
// Optional FC_CTRL_PERF_EN adds perf_cycles (first accept to result, saturating).
module fc_ctrl
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = FC_DATA_W,
  parameter int unsigned N_IN   = FC_N_IN,
  parameter int unsigned CNT_W  = FC_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              fc_valid,
  output logic [DATA_W-1:0] fc_data,
  input  logic [3:0]        fc_class,
  output logic              m_valid,
  output logic [3:0]        m_class,
  input  logic              m_ready,
  output logic [15:0]       frame_cnt,
  output logic              busy
`ifdef FC_CTRL_PERF_EN
  ,
  output logic [15:0]       perf_cycles
`endif
);

  fc_ctrl_state_t state_q, state_d;

  logic              s_ready_q, s_ready_d;
  logic              fc_valid_q, fc_valid_d;
  logic [DATA_W-1:0] fc_data_q, fc_data_d;
  logic              m_valid_q, m_valid_d;
  logic [3:0]        m_class_q, m_class_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              busy_q, busy_d;

  logic              wr_en_c;
  logic              rd_en_c;
  logic [DATA_W-1:0] rd_data_c;
  logic              wr_last_c;
  logic              rd_done_c;
`ifdef FC_CTRL_PERF_EN
  logic              wr_first_c;
`endif

  assign wr_en_c = (state_q == FC_FILL) && s_valid;
  assign rd_en_c = (state_q == FC_STREAM) && !rd_done_c;

  fc_feat_buf #(
    .DATA_W (DATA_W),
    .N_IN   (N_IN),
    .CNT_W  (CNT_W)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en_c),
    .wr_data    (s_data),
    .rd_en      (rd_en_c),
    .rd_data_c  (rd_data_c),
    .wr_last_c  (wr_last_c),
    .rd_done_c  (rd_done_c),
`ifdef FC_CTRL_PERF_EN
    .wr_first_c (wr_first_c)
`else
    .wr_first_c ()
`endif
  );

  // STREAM spends one extra cycle with the read index parked at N_IN, which
  // drops fc_valid so WAIT lands exactly one cycle after the last beat.
  always_comb begin
    state_d     = state_q;
    fc_valid_d  = 1'b0;
    fc_data_d   = '0;
    m_valid_d   = m_valid_q;
    m_class_d   = m_class_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      FC_FILL: begin
        if (s_valid && wr_last_c) begin
          state_d = FC_STREAM;
        end
      end
      FC_STREAM: begin
        if (rd_done_c) begin
          state_d = FC_WAIT;
        end else begin
          fc_valid_d = 1'b1;
          fc_data_d  = rd_data_c;
        end
      end
      FC_WAIT: begin
        m_valid_d   = 1'b1;
        m_class_d   = fc_class;
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = FC_HOLD;
      end
      FC_HOLD: begin
        if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
          state_d   = FC_FILL;
        end
      end
      default: begin
        state_d = FC_FILL;
      end
    endcase
    s_ready_d = (state_d == FC_FILL);
    busy_d    = (state_d != FC_FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FC_FILL;
      s_ready_q   <= 1'b1;
      fc_valid_q  <= 1'b0;
      fc_data_q   <= '0;
      m_valid_q   <= 1'b0;
      m_class_q   <= '0;
      frame_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_ready_q   <= s_ready_d;
      fc_valid_q  <= fc_valid_d;
      fc_data_q   <= fc_data_d;
      m_valid_q   <= m_valid_d;
      m_class_q   <= m_class_d;
      frame_cnt_q <= frame_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign fc_valid  = fc_valid_q;
  assign fc_data   = fc_data_q;
  assign m_valid   = m_valid_q;
  assign m_class   = m_class_q;
  assign frame_cnt = frame_cnt_q;
  assign busy      = busy_q;

`ifdef FC_CTRL_PERF_EN
  logic [15:0] run_cnt_q, run_cnt_d;
  logic [15:0] perf_q, perf_d;

  // run_cnt counts inclusively from the first accept; zero means no frame started yet.
  always_comb begin
    run_cnt_d = run_cnt_q;
    perf_d    = perf_q;
    if (wr_en_c && wr_first_c) begin
      run_cnt_d = 16'd1;
    end else if ((run_cnt_q != 16'd0) && (run_cnt_q != 16'hFFFF)) begin
      run_cnt_d = run_cnt_q + 16'd1;
    end
    if (state_q == FC_WAIT) begin
      perf_d = (run_cnt_q == 16'hFFFF) ? 16'hFFFF : run_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_q <= '0;
      perf_q    <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
      perf_q    <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_fc_ctrl.sv
// Self-checking bench for fc_ctrl with a behavioural fc_layer stand-in (class = feature sum mod 10).
module tb_fc_ctrl;

  localparam int N = 48;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready;
  logic        fc_valid;
  logic [7:0]  fc_data;
  logic [3:0]  fc_class;
  logic        m_valid;
  logic [3:0]  m_class;
  logic        m_ready = 1'b0;
  logic [15:0] frame_cnt;
  logic        busy;
`ifdef FC_CTRL_PERF_EN
  logic [15:0] perf_cycles;
`endif

  int n_vec = 0;
  int n_err = 0;
  int exp_frames = 0;
  int exp_class = 0;
  logic [7:0] feat [N];

  always #5 clk = ~clk;

  fc_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .fc_valid  (fc_valid),
    .fc_data   (fc_data),
    .fc_class  (fc_class),
    .m_valid   (m_valid),
    .m_class   (m_class),
    .m_ready   (m_ready),
    .frame_cnt (frame_cnt),
    .busy      (busy)
`ifdef FC_CTRL_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  function automatic int cls_of(input int s);
    return ((s % 10) + 10) % 10;
  endfunction

  // fc_layer stand-in: counts beats itself and registers its class on the 48th beat (sticky).
  int stub_cnt;
  int stub_acc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_cnt <= 0;
      stub_acc <= 0;
      fc_class <= '0;
    end else if (fc_valid) begin
      if (stub_cnt == N - 1) begin
        stub_cnt <= 0;
        stub_acc <= 0;
        fc_class <= 4'(cls_of(stub_acc + int'($signed(fc_data))));
      end else begin
        stub_cnt <= stub_cnt + 1;
        stub_acc <= stub_acc + int'($signed(fc_data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 1);
    chk({tag, "_fc_valid"}, 32'(fc_valid), 0);
    chk({tag, "_fc_data"}, 32'(fc_data), 0);
    chk({tag, "_m_valid"}, 32'(m_valid), 0);
    chk({tag, "_m_class"}, 32'(m_class), 0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Feed one frame; returns in the cycle right after the last accept edge.
  task automatic fill_frame(input int gap_pct, input bit seq);
    int idx = 0;
    int cyc = 0;
    int sum = 0;
    for (int i = 0; i < N; i++) begin
      feat[i] = seq ? 8'(i + 1) : 8'($urandom);
      sum += int'($signed(feat[i]));
    end
    exp_class = cls_of(sum);
    while (idx < N && cyc < 4000) begin
      chk("fill_s_ready", 32'(s_ready), 1);
      chk("fill_fc_valid", 32'(fc_valid), 0);
      chk("fill_busy", 32'(busy), 0);
      s_valid = (int'($urandom_range(99)) >= gap_pct);
      s_data  = s_valid ? feat[idx] : 8'($urandom);
      tick();
      if (s_valid) idx++;
      cyc++;
    end
    s_valid = 1'b0;
    chk("fill_done", 32'(idx), 32'(N));
  endtask

  // Replay window: beats in cycles T+1..T+48, gap at T+49, result at T+50.
  task automatic stream_frame();
    exp_frames++;
    chk("strm_s_ready_drop", 32'(s_ready), 0);
    chk("strm_busy", 32'(busy), 1);
    chk("strm_fc_valid_t0", 32'(fc_valid), 0);
    for (int c = 1; c <= N + 1; c++) begin
      tick();
      chk("strm_fc_valid", 32'(fc_valid), (c <= N) ? 1 : 0);
      if (c <= N) chk("strm_fc_data", 32'(fc_data), 32'(feat[c-1]));
      chk("strm_m_valid_early", 32'(m_valid), 0);
      chk("strm_s_ready", 32'(s_ready), 0);
    end
    tick();
    chk("res_m_valid", 32'(m_valid), 1);
    chk("res_m_class", 32'(m_class), 32'(exp_class));
    chk("res_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    chk("res_fc_valid", 32'(fc_valid), 0);
  endtask

  task automatic release_result(input int hold, input bit keep_ready);
    if (hold > 0) m_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_m_valid", 32'(m_valid), 1);
      chk("hold_m_class", 32'(m_class), 32'(exp_class));
      chk("hold_s_ready", 32'(s_ready), 0);
      chk("hold_fc_valid", 32'(fc_valid), 0);
    end
    m_ready = 1'b1;
    tick();
    chk("rel_m_valid", 32'(m_valid), 0);
    chk("rel_s_ready", 32'(s_ready), 1);
    chk("rel_busy", 32'(busy), 0);
    chk("rel_fc_valid", 32'(fc_valid), 0);
    m_ready = keep_ready;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick();

    // Sequential features 1..48, back-to-back fill
    fill_frame(0, 1'b1);
    stream_frame();
    chk("seq_class_golden", 32'(m_class), 6);
`ifdef FC_CTRL_PERF_EN
    chk("perf_cycles", 32'(perf_cycles), 98);
`endif
    release_result(0, 1'b0);

    // Random features with ~50% valid gaps, then a 20-cycle stall on m_ready
    fill_frame(50, 1'b0);
    stream_frame();
    release_result(20, 1'b0);

    // Three frames back-to-back with m_ready held high throughout
    m_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      fill_frame(0, 1'b0);
      stream_frame();
      release_result(0, 1'b1);
    end
    chk("b2b_frame_cnt", 32'(frame_cnt), 5);
    m_ready = 1'b0;

    // Reset asserted at beat 20 of STREAM
    fill_frame(0, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk("pre_rst_fc_valid", 32'(fc_valid), 1);
    end
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    tick();
    tick();
    chk_reset_vals("midrst_hold");
    rst_n = 1'b1;
    exp_frames = 0;
    tick();

    // Fresh frame after reset must classify with fc_layer realigned
    fill_frame(25, 1'b0);
    stream_frame();
    release_result(3, 1'b0);
    chk("post_rst_frame_cnt", 32'(frame_cnt), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
